// File: rtl/switch_pio_irq.sv
// -----------------------------------------------------------------------------
// switch_pio_irq
//   Avalon-MM input PIO for board switches and push-buttons. Each input bit is
//   synchronised, debounced and published as DATA. Selected edges of the
//   debounced value are latched into a write-1-to-clear EDGECAP register. A
//   per-bit IRQMASK gates EDGECAP onto a level interrupt.
//
//   Register map (word address, read data zero-extended from WIDTH):
//     0 DATA     debounced value, read-only
//     1 reserved reads 0
//     2 IRQMASK  read/write
//     3 EDGECAP  read, write-1-to-clear
//
// Parameters
//   WIDTH           input bits, 1..32
//   SYNC_STAGES     synchroniser depth, >= 2
//   DEBOUNCE_CYCLES cycles a new level must persist before it is accepted, >= 1
//   EDGE_TYPE       0 rising, 1 falling, 2 any edge
//
// Ports
//   clk        single clock, rising edge
//   reset      synchronous active-high reset
//   address    word address
//   chipselect slave select
//   write_n    active-low write strobe, qualified by chipselect
//   writedata  write data
//   in_port    asynchronous inputs
//   readdata   registered read data, latency 1
//   irq        level interrupt, |(EDGECAP & IRQMASK)
// -----------------------------------------------------------------------------
module switch_pio_irq #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Debounce counter needs at least one bit even when no filtering is done.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Prime counter saturates at SYNC_STAGES+1: by then the sync chain holds
  // only post-reset samples and stable has been loaded from them.
  localparam int PRIME_W = $clog2(SYNC_STAGES + 2);
  localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(SYNC_STAGES + 1);
  localparam logic [PRIME_W-1:0] PRIME_ONE = PRIME_W'(1);

  localparam logic [1:0] EDGE_SEL = 2'(EDGE_TYPE);
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

  // Zero-extend a WIDTH-bit register onto the 32-bit bus.
  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    zext = 32'(v);
  endfunction

  logic [WIDTH-1:0]   sync_r [SYNC_STAGES];
  logic [WIDTH-1:0]   stable_r;
  logic [CNT_W-1:0]   cnt_r [WIDTH];
  logic [PRIME_W-1:0] prime_r;
  logic [WIDTH-1:0]   irqmask_r;
  logic [WIDTH-1:0]   edgecap_r;

  logic [WIDTH-1:0]   sync_s;
  logic               primed_s;
  logic [WIDTH-1:0]   stable_nxt_s;
  logic [CNT_W-1:0]   cnt_nxt_s [WIDTH];
  logic [WIDTH-1:0]   rise_s;
  logic [WIDTH-1:0]   fall_s;
  logic [WIDTH-1:0]   edge_s;
  logic               wr_s;
  logic [WIDTH-1:0]   clr_s;
  logic [WIDTH-1:0]   edgecap_nxt_s;
  logic [31:0]        rd_nxt_s;
  logic               wd_unused_s;

  assign sync_s   = sync_r[SYNC_STAGES-1];
  assign primed_s = (prime_r == PRIME_DONE);
  assign wr_s     = chipselect & ~write_n;

  // Bits of writedata above WIDTH carry no meaning for this register set.
  assign wd_unused_s = ^writedata;

  // Per-bit debounce: a differing level must persist DEBOUNCE_CYCLES cycles.
  always_comb begin
    stable_nxt_s = stable_r;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt_s[i] = CNT_ZERO;
      if (!primed_s) begin
        // Priming: follow the synchroniser directly, no filtering.
        stable_nxt_s[i] = sync_s[i];
        cnt_nxt_s[i]    = CNT_ZERO;
      end else if (sync_s[i] == stable_r[i]) begin
        cnt_nxt_s[i] = CNT_ZERO;
      end else if (cnt_r[i] == CNT_MAX) begin
        stable_nxt_s[i] = sync_s[i];
        cnt_nxt_s[i]    = CNT_ZERO;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  // Edge selection on the transition stable_r -> stable_nxt_s.
  always_comb begin
    rise_s = ~stable_r & stable_nxt_s;
    fall_s = stable_r & ~stable_nxt_s;
    case (EDGE_SEL)
      2'd0:    edge_s = rise_s;
      2'd1:    edge_s = fall_s;
      2'd2:    edge_s = rise_s | fall_s;
      default: edge_s = rise_s;
    endcase
    // Priming loads are not real input transitions.
    if (!primed_s) begin
      edge_s = ZERO_W;
    end else begin
      edge_s = edge_s;
    end
  end

  // EDGECAP next state: clear first, then OR in new edges so a set wins.
  always_comb begin
    if (wr_s && (address == 2'd3)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = ZERO_W;
    end
    edgecap_nxt_s = (edgecap_r & ~clr_s) | edge_s;
  end

  // Read multiplexer, registered below for a fixed one-cycle latency.
  always_comb begin
    case (address)
      2'd0:    rd_nxt_s = zext(stable_r);
      2'd1:    rd_nxt_s = 32'd0;
      2'd2:    rd_nxt_s = zext(irqmask_r);
      2'd3:    rd_nxt_s = zext(edgecap_r);
      default: rd_nxt_s = 32'd0;
    endcase
  end

  // State registers: synchroniser, debounce, priming, bus registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= ZERO_W;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
      stable_r  <= ZERO_W;
      prime_r   <= {PRIME_W{1'b0}};
      irqmask_r <= ZERO_W;
      edgecap_r <= ZERO_W;
      readdata  <= 32'd0;
    end else begin
      sync_r[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      stable_r <= stable_nxt_s;
      if (!primed_s) begin
        prime_r <= prime_r + PRIME_ONE;
      end else begin
        prime_r <= prime_r;
      end
      if (wr_s && (address == 2'd2)) begin
        irqmask_r <= writedata[WIDTH-1:0];
      end else begin
        irqmask_r <= irqmask_r;
      end
      edgecap_r <= edgecap_nxt_s;
      readdata  <= rd_nxt_s;
    end
  end

  // Interrupt is a pure AND/OR of two flops, no path from bus inputs.
  assign irq = |(edgecap_r & irqmask_r);

endmodule

// File: tb/tb_switch_pio_irq.sv
// -----------------------------------------------------------------------------
// tb_switch_pio_irq
//   Three instances share clock, reset, bus and input pins:
//     u0: WIDTH 8,  SYNC 2, DEBOUNCE 1, rising
//     u1: WIDTH 8,  SYNC 2, DEBOUNCE 4, falling
//     u2: WIDTH 32, SYNC 3, DEBOUNCE 4, any edge
//   A behavioural model (input history, acceptance window, register map) is
//   stepped at every rising edge and compared against all outputs at the
//   falling edge; directed scenarios add explicit constant checks.
// -----------------------------------------------------------------------------
module tb_switch_pio_irq;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] pins;

  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  switch_pio_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(0)) u0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(pins[7:0]),
    .readdata(rd0), .irq(irq0));

  switch_pio_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) u1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(pins[7:0]),
    .readdata(rd1), .irq(irq1));

  switch_pio_irq #(.WIDTH(32), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(pins),
    .readdata(rd2), .irq(irq2));

  // ---------------------------------------------------------------- model
  function automatic int cfg_s(int k); return (k == 2) ? 3 : 2; endfunction
  function automatic int cfg_d(int k); return (k == 0) ? 1 : 4; endfunction
  function automatic logic [31:0] cfg_wm(int k);
    return (k == 2) ? 32'hFFFF_FFFF : 32'h0000_00FF;
  endfunction

  logic [31:0] in_hist[$];
  int          n_since = 0;
  logic [31:0] m_stable[3];
  logic [31:0] m_cap[3];
  logic [31:0] m_mask[3];
  logic [31:0] m_rd[3];
  int          m_pc[3];
  logic [31:0] m_win[3][4];
  int          m_wn[3];

  task automatic model_reset();
    in_hist.delete();
    n_since = 0;
    for (int k = 0; k < 3; k++) begin
      m_stable[k] = 32'h0; m_cap[k] = 32'h0; m_mask[k] = 32'h0;
      m_rd[k] = 32'h0; m_pc[k] = 0; m_wn[k] = 0;
    end
  endtask

  task automatic model_step();
    logic [31:0] wm, sy, acc, nst, ev, clr;
    logic        wr;
    int          s, d, e;
    if (reset) begin
      model_reset();
      return;
    end
    in_hist.push_back(pins);
    n_since++;
    if (in_hist.size() > 8) void'(in_hist.pop_front());
    wr = chipselect && !write_n;
    for (int k = 0; k < 3; k++) begin
      s = cfg_s(k); d = cfg_d(k); e = k; wm = cfg_wm(k);
      // The level the debouncer sees now is the pin value from s edges ago.
      sy = (n_since > s) ? (in_hist[in_hist.size() - 1 - s] & wm) : 32'h0;
      case (address)
        2'd0:    m_rd[k] = m_stable[k];
        2'd2:    m_rd[k] = m_mask[k];
        2'd3:    m_rd[k] = m_cap[k];
        default: m_rd[k] = 32'h0;
      endcase
      clr = (wr && address == 2'd3) ? (writedata & wm) : 32'h0;
      ev  = 32'h0;
      if (m_pc[k] < s + 1) begin
        nst = sy;
        m_pc[k]++;
        m_wn[k] = 0;
      end else begin
        for (int j = 3; j > 0; j--) m_win[k][j] = m_win[k][j-1];
        m_win[k][0] = sy;
        if (m_wn[k] < 4) m_wn[k]++;
        // Accept bits whose last d sampled levels all differ from stable.
        acc = wm;
        for (int j = 0; j < d; j++) begin
          if (j < m_wn[k]) acc = acc & (m_win[k][j] ^ m_stable[k]);
          else acc = 32'h0;
        end
        nst = m_stable[k] ^ acc;
        if (e == 0) ev = acc & nst;
        else if (e == 1) ev = acc & ~nst;
        else ev = acc;
      end
      m_cap[k] = (m_cap[k] & ~clr) | ev;
      m_stable[k] = nst;
      if (wr && address == 2'd2) m_mask[k] = writedata & wm;
    end
  endtask

  // ---------------------------------------------------------------- checks
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check_eq("rd0", rd0, m_rd[0]);
    check_eq("rd1", rd1, m_rd[1]);
    check_eq("rd2", rd2, m_rd[2]);
    check_eq("irq0", {31'd0, irq0}, {31'd0, |(m_cap[0] & m_mask[0])});
    check_eq("irq1", {31'd0, irq1}, {31'd0, |(m_cap[1] & m_mask[1])});
    check_eq("irq2", {31'd0, irq2}, {31'd0, |(m_cap[2] & m_mask[2])});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
  endtask

  task automatic read_reg(input logic [1:0] a);
    address = a;
    tick();
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic seen;
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'h0; pins = 32'hFFFF_FFFF;
    model_reset();

    // Reset with inputs held high, then release: no spurious events.
    ticks(3);
    check_eq("rst_rd0", rd0, 32'h0);
    check_eq("rst_irq2", {31'd0, irq2}, 32'h0);
    reset = 1'b0;
    ticks(10);
    check_eq("prime_data0", rd0, 32'h0000_00FF);
    check_eq("prime_data1", rd1, 32'h0000_00FF);
    check_eq("prime_data2", rd2, 32'hFFFF_FFFF);
    read_reg(2'd3);
    check_eq("prime_cap0", rd0, 32'h0);
    check_eq("prime_cap2", rd2, 32'h0);
    check_eq("prime_irq0", {31'd0, irq0}, 32'h0);

    // Rising edge on bit0 with mask 0x01: irq exactly 3 cycles after.
    pins = 32'h0;
    ticks(10);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_write(2'd2, 32'h0000_0001);
    address = 2'd3;
    pins[0] = 1'b1;
    ticks(2);
    check_eq("irq_early", {31'd0, irq0}, 32'h0);
    tick();
    check_eq("irq_rise", {31'd0, irq0}, 32'h1);
    tick();
    check_eq("cap_rise", rd0, 32'h1);
    bus_write(2'd3, 32'h0000_0001);
    check_eq("irq_clr", {31'd0, irq0}, 32'h0);

    // Debounce: 3-cycle pulse rejected, 4-cycle pulse accepted.
    ticks(10);
    bus_write(2'd3, 32'hFFFF_FFFF);
    pins[2] = 1'b1; ticks(3); pins[2] = 1'b0;
    address = 2'd0; ticks(10);
    check_eq("glitch_data1", rd1, 32'h1);
    read_reg(2'd3);
    check_eq("glitch_cap1", rd1, 32'h0);
    check_eq("glitch_cap2", rd2, 32'h0);
    pins[2] = 1'b1; ticks(4); pins[2] = 1'b0;
    address = 2'd0; seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rd1[2]) seen = 1'b1;
    end
    check_eq("pulse_seen1", {31'd0, seen}, 32'h1);
    check_eq("pulse_data1", rd1, 32'h1);
    read_reg(2'd3);
    check_eq("pulse_cap1", rd1, 32'h4);
    check_eq("pulse_cap2", rd2, 32'h4);

    // Edge type: bit5 rise then fall.
    bus_write(2'd3, 32'hFFFF_FFFF);
    pins[5] = 1'b1; address = 2'd3; ticks(10);
    check_eq("e_rise_fall", rd1, 32'h0);
    check_eq("e_rise_any", rd2, 32'h20);
    check_eq("e_rise_rise", rd0, 32'h20);
    pins[5] = 1'b0; ticks(10);
    check_eq("e_fall_fall", rd1, 32'h20);

    // Clear and edge on bit3 in the same cycle: set wins.
    bus_write(2'd3, 32'hFFFF_FFFF);
    pins[3] = 1'b1; ticks(2);
    address = 2'd3; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h8;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    tick();
    check_eq("set_wins", rd0, 32'h8);

    // Full-width instance, reserved word, DATA write ignored.
    pins = 32'hFFFF_FFFF; ticks(10);
    read_reg(2'd0);
    check_eq("w32_data", rd2, 32'hFFFF_FFFF);
    read_reg(2'd1);
    check_eq("w32_resv", rd2, 32'h0);
    bus_write(2'd0, 32'h0);
    read_reg(2'd0);
    check_eq("w32_ro", rd2, 32'hFFFF_FFFF);

    // Reset in the middle of a debounce, then release with inputs low.
    pins = 32'h0; ticks(5);
    reset = 1'b1; ticks(2);
    check_eq("mid_rst_rd2", rd2, 32'h0);
    check_eq("mid_rst_irq2", {31'd0, irq2}, 32'h0);
    reset = 1'b0; ticks(12);
    read_reg(2'd3);
    check_eq("mid_cap2", rd2, 32'h0);
    check_eq("mid_cap1", rd1, 32'h0);
    read_reg(2'd2);
    check_eq("mid_mask2", rd2, 32'h0);
    read_reg(2'd0);
    check_eq("mid_data2", rd2, 32'h0);

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 9))
        0, 1:    pins = pins ^ (32'h1 << $urandom_range(0, 31));
        2:       pins = $urandom;
        default: pins = pins;
      endcase
      address    = 2'($urandom_range(0, 3));
      chipselect = ($urandom_range(0, 3) == 0);
      write_n    = 1'($urandom_range(0, 1));
      writedata  = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
